// File: rtl/fpga_cfg_pkg.sv
// fpga_cfg_pkg: shared fixed-point configuration and solver-arbiter types.
// Contents:
//   FP_WIDTH / FP_FRAC : fixed-point word layout (Q16.16)
//   MAT_ENTRIES        : entries in a 3x3 augmented normal-equation matrix (3x4)
//   BETA_N             : number of regression coefficients returned
//   rsp_err_e          : response status code sent back to a lane
//   arb_state_e        : solver arbiter FSM states
//   wrap_inc()         : modulo-n increment used for the round-robin pointer
package fpga_cfg_pkg;

  localparam int FP_WIDTH    = 32;
  localparam int FP_FRAC     = 16;
  localparam int MAT_ENTRIES = 12;
  localparam int BETA_N      = 3;

  typedef enum logic [1:0] {
    RSP_OK       = 2'd0,
    RSP_SINGULAR = 2'd1,
    RSP_TIMEOUT  = 2'd2
  } rsp_err_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  // Increment idx, wrapping to 0 at n (works for non-power-of-two n).
  function automatic int wrap_inc(input int idx, input int n);
    int nxt;
    nxt = idx + 1;
    if (nxt >= n) begin
      nxt = 0;
    end else begin
      nxt = idx + 1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
// The request vector is rotated so that lane `ptr` sits at bit 0, the lowest
// set bit of the rotated vector is found, and the offset is rotated back into
// an absolute lane index.
// Ports:
//   req   [N]          : request vector, one bit per lane
//   ptr   [log2 N]     : lane holding highest priority this round
//   grant [log2 N]     : chosen lane (meaningful only when any=1)
//   any                : at least one request is pending
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] grant,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [N-1:0]  rot_s;
  logic [IW-1:0] idx_s;
  int            off_s;

  // Rotate, priority-encode lowest set bit, unrotate.
  always_comb begin
    rot_s = '0;
    idx_s = '0;
    off_s = 0;
    for (int i = 0; i < N; i++) begin
      idx_s    = IW'((i + int'(ptr)) % N);
      rot_s[i] = req[idx_s];
    end
    // Scan downward so the lowest set offset is the one left standing.
    for (int i = N - 1; i >= 0; i--) begin
      off_s = rot_s[i] ? i : off_s;
    end
    grant = IW'((off_s + int'(ptr)) % N);
    any   = |req;
  end

endmodule

// File: rtl/solver_arbiter.sv
// solver_arbiter: shares one 3x3 regression solver among N_REQ accumulator
// lanes. Lanes are granted round-robin, the granted matrix is latched and
// offered to the solver, a watchdog bounds the solve, and beta (or an error
// code) is returned to the owning lane with a one-cycle pulse.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   req_valid[N_REQ]          : lane has a matrix pending
//   req_mat[N_REQ][12]        : row-major augmented matrix per lane
//   req_ready[N_REQ]          : one-cycle accept pulse to the granted lane
//   rsp_valid[N_REQ]          : one-cycle result pulse to the owning lane
//   rsp_beta[3], rsp_err      : shared result bus and status (0 OK/1 SING/2 TMO)
//   busy                      : arbiter not idle
//   owner                     : current/last granted lane
//   slv_valid_in, slv_mat[12] : matrix offered to the solver
//   slv_ready                 : solver accepts the matrix
//   slv_valid_out, slv_singular, slv_beta[3] : solver result
module solver_arbiter
  import fpga_cfg_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = FP_WIDTH,
  parameter int TIMEOUT = 4096
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic signed [WIDTH-1:0]     req_mat [N_REQ][MAT_ENTRIES],
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic signed [WIDTH-1:0]     rsp_beta [BETA_N],
  output logic [1:0]                  rsp_err,
  output logic                        busy,
  output logic [$clog2(N_REQ)-1:0]    owner,
  output logic                        slv_valid_in,
  output logic signed [WIDTH-1:0]     slv_mat [MAT_ENTRIES],
  input  logic                        slv_ready,
  input  logic                        slv_valid_out,
  input  logic                        slv_singular,
  input  logic signed [WIDTH-1:0]     slv_beta [BETA_N]
);

  localparam int IW  = $clog2(N_REQ);
  localparam int WDW = $clog2(TIMEOUT) + 1;

  arb_state_e              state_r, state_s;
  logic [N_REQ-1:0]        req_ready_r, req_ready_s;
  logic [N_REQ-1:0]        rsp_valid_r, rsp_valid_s;
  logic signed [WIDTH-1:0] beta_r [BETA_N];
  logic signed [WIDTH-1:0] beta_s [BETA_N];
  rsp_err_e                err_r, err_s;
  logic                    busy_r, busy_s;
  logic [IW-1:0]           owner_r, owner_s;
  logic [IW-1:0]           ptr_r, ptr_s;
  logic                    vin_r, vin_s;
  logic signed [WIDTH-1:0] mat_r [MAT_ENTRIES];
  logic signed [WIDTH-1:0] mat_s [MAT_ENTRIES];
  logic [WDW-1:0]          wdog_r, wdog_s;
  logic [IW-1:0]           pick_s;
  logic                    any_s;

  rr_pick #(.N(N_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (ptr_r),
    .grant (pick_s),
    .any   (any_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Output, datapath and watchdog registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r <= '0;
      rsp_valid_r <= '0;
      err_r       <= RSP_OK;
      busy_r      <= 1'b0;
      owner_r     <= '0;
      ptr_r       <= '0;
      vin_r       <= 1'b0;
      wdog_r      <= '0;
      for (int j = 0; j < BETA_N; j++) begin
        beta_r[j] <= '0;
      end
      for (int j = 0; j < MAT_ENTRIES; j++) begin
        mat_r[j] <= '0;
      end
    end else begin
      req_ready_r <= req_ready_s;
      rsp_valid_r <= rsp_valid_s;
      err_r       <= err_s;
      busy_r      <= busy_s;
      owner_r     <= owner_s;
      ptr_r       <= ptr_s;
      vin_r       <= vin_s;
      wdog_r      <= wdog_s;
      beta_r      <= beta_s;
      mat_r       <= mat_s;
    end
  end

  // Next-state and next-register-value logic.
  always_comb begin
    state_s     = state_r;
    req_ready_s = '0;
    rsp_valid_s = '0;
    beta_s      = beta_r;
    err_s       = err_r;
    owner_s     = owner_r;
    ptr_s       = ptr_r;
    vin_s       = vin_r;
    mat_s       = mat_r;
    wdog_s      = wdog_r;

    case (state_r)
      ST_IDLE: begin
        if (any_s) begin
          owner_s             = pick_s;
          mat_s               = req_mat[pick_s];
          req_ready_s[pick_s] = 1'b1;
          vin_s               = 1'b1;
          state_s             = ST_ISSUE;
        end else begin
          vin_s = 1'b0;
        end
      end

      ST_ISSUE: begin
        if (slv_ready) begin
          vin_s   = 1'b0;
          wdog_s  = '0;
          state_s = ST_WAIT;
        end else begin
          vin_s = 1'b1;
        end
      end

      ST_WAIT: begin
        wdog_s = wdog_r + WDW'(1);
        // Priority: real result, then bare singular flag, then watchdog.
        if (slv_valid_out) begin
          beta_s               = slv_beta;
          err_s                = slv_singular ? RSP_SINGULAR : RSP_OK;
          rsp_valid_s[owner_r] = 1'b1;
          state_s              = ST_RESP;
        end else if (slv_singular) begin
          for (int j = 0; j < BETA_N; j++) begin
            beta_s[j] = '0;
          end
          err_s                = RSP_SINGULAR;
          rsp_valid_s[owner_r] = 1'b1;
          state_s              = ST_RESP;
        end else if (wdog_r == WDW'(TIMEOUT - 1)) begin
          for (int j = 0; j < BETA_N; j++) begin
            beta_s[j] = '0;
          end
          err_s                = RSP_TIMEOUT;
          rsp_valid_s[owner_r] = 1'b1;
          state_s              = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end

      ST_RESP: begin
        // Lane after the one just served gets first priority next round.
        ptr_s   = IW'(wrap_inc(int'(owner_r), N_REQ));
        state_s = ST_IDLE;
      end

      default: begin
        vin_s   = 1'b0;
        state_s = ST_IDLE;
      end
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  assign req_ready    = req_ready_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_beta     = beta_r;
  assign rsp_err      = err_r;
  assign busy         = busy_r;
  assign owner        = owner_r;
  assign slv_valid_in = vin_r;
  assign slv_mat      = mat_r;

endmodule

// File: doc/solver_arbiter.md
# solver_arbiter

Shares one 3×3 regression solver among `N_REQ` accumulator lanes. Each lane computes its normal-equation sums in parallel and posts a 12-entry augmented matrix. The arbiter grants lanes round-robin, drives the solver handshake, and watches for a hung solve with a watchdog. It routes β, or an error code, back to the owning lane. It sits between the per-lane accumulators and the single shared `regression` instance.

## Interface
Parameters:
- `N_REQ`, 4: number of requesting lanes (≥2)
- `WIDTH`, `fpga_cfg_pkg::FP_WIDTH`: fixed-point word width
- `TIMEOUT`, 4096: maximum cycles in WAIT before an abort

Ports:
- `clk`, in, 1: clock
- `rst_n`, in, 1: reset, asynchronous, active-low
- `req_valid`, in, [N_REQ]: lane i has a matrix pending
- `req_mat`, in, [N_REQ][0:11]×WIDTH signed: row-major augmented matrix per lane
- `req_ready`, out, [N_REQ]: one-cycle accept pulse to the granted lane
- `rsp_valid`, out, [N_REQ]: one-cycle result pulse to the owning lane
- `rsp_beta`, out, [0:2]×WIDTH signed: shared result bus, meaningful only with `rsp_valid`
- `rsp_err`, out, 2: 0 OK, 1 SINGULAR, 2 TIMEOUT
- `busy`, out, 1: high in every state except IDLE
- `owner`, out, $clog2(N_REQ): current/last granted lane
- `slv_valid_in`, out, 1: matrix offered to the solver
- `slv_mat`, out, [0:11]×WIDTH signed: latched matrix
- `slv_ready`, in, 1: solver accepts
- `slv_valid_out`, in, 1: solver result valid
- `slv_singular`, in, 1: solver singular flag
- `slv_beta`, in, [0:2]×WIDTH signed: solver result

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**
  - If any `req_valid` is high, pick a lane round-robin starting at `ptr`.
  - Latch `req_mat[g]` into `mat_q` and set `owner` to g.
  - Register `req_ready[g]`=1 for the next cycle, then go to ISSUE.
- **Lane obligation:** `req_valid` and `req_mat` stay stable until the lane sees `req_ready`. The lane may drop them after that cycle.
- **ISSUE**
  - `slv_valid_in`=1 and `slv_mat`=`mat_q` are held until a cycle with `slv_ready`=1.
  - On that edge: go to WAIT, clear the watchdog, deassert `slv_valid_in`.
- **WAIT**
  - The watchdog increments every cycle.
  - If `slv_valid_out`=1: capture `slv_beta`, set err = `slv_singular` ? SINGULAR : OK, go to RESP.
  - Else if `slv_singular`=1 alone: err=SINGULAR, β=0, go to RESP.
  - Else if the watchdog equals TIMEOUT−1: err=TIMEOUT, β=0, go to RESP.
  - If a result and the timeout coincide, the solver result wins.
- **RESP**
  - `rsp_valid[owner]`=1 for exactly one cycle, with `rsp_beta`/`rsp_err` driven from registers.
  - Set `ptr` = (owner+1) mod N_REQ, then go to IDLE.
  - Responses cannot be back-pressured; lanes must sample them in that cycle.
- Outside WAIT, `slv_valid_out` and `slv_singular` are ignored.
- `req_valid` from non-owners is ignored until IDLE. Their requests stay pending, with no loss or reorder within a lane.
- On a SINGULAR result, the lane is responsible for its own fallback (mean payoff). The arbiter never retries.

## Timing
- All outputs are registered.
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_beta`=0, `rsp_err`=0, `busy`=0, `owner`=0, `slv_valid_in`=0, `slv_mat`=0. Internal `ptr`=0, so lane 0 has first priority after reset.
- Request sampled in IDLE at edge k:
  - `req_ready` and `slv_valid_in` are high in cycle k+1.
  - With `slv_ready`=1, the transfer happens at edge k+2.
- Solver result at edge m → `rsp_valid` high in cycle m+1.
- Minimum IDLE→IDLE overhead beyond solver latency is 3 cycles. The next grant can be sampled the cycle after RESP.
- Reset asserted mid-operation (any state) forces IDLE immediately and drops all outputs to their reset values. A pending solve is abandoned; the solver shares `rst_n`.
- Fairness: with all lanes continuously requesting, each lane is granted once per N_REQ transactions.

## Structure
- Add to `fpga_cfg_pkg`:
  - `localparam MAT_ENTRIES=12`
  - `localparam BETA_N=3`
  - `typedef enum logic [1:0] {RSP_OK, RSP_SINGULAR, RSP_TIMEOUT} rsp_err_e`
- Sub-module `rr_pick #(N)`: combinational round-robin picker.
  - Inputs: request vector, `ptr`.
  - Outputs: grant index, any-request flag.
  - Implementation: rotate, priority-encode, unrotate.

## Test plan
1. **Single request:** lane 2 requests with `slv_ready`=1 and the solver returns β=(1.0, 0.5, −0.25) after 20 cycles → `req_ready[2]` pulse, `rsp_valid[2]` one cycle, `rsp_err`=0, bus equals the solver β, then `ptr`=3.
2. **Fairness:** all 4 lanes request continuously for 8 transactions → grant order 0,1,2,3,0,1,2,3, and no `rsp_valid` reaches a non-owner.
3. **Singular:** the solver asserts `slv_singular` with `slv_valid_out` → `rsp_err`=1 and the captured β is forwarded. Singular asserted without valid → `rsp_err`=1 and β=0.
4. **Timeout:** with TIMEOUT=16, the solver never responds → `rsp_valid` exactly 16 cycles after entering WAIT, `rsp_err`=2, β=0. Result and timeout on the same cycle → `rsp_err`=0.
5. **Back-pressure:** `slv_ready` held low for 10 cycles → `slv_valid_in` and `slv_mat` stay stable for all 10 cycles, and a lane-1 `req_mat` change after its `req_ready` does not alter `slv_mat`.
6. **Reset in WAIT:** assert `rst_n`=0 for 2 cycles → all outputs at reset values, `busy`=0, and after release a lane-3-only request is granted first.
